clk_div_multi: RTL and testbench

- Parametrised multi-channel successor to the TX PHY single-output PCLK divider.
- Generates NUM_CH independent divided clocks from one high-speed clock. Each channel supports any integer ratio 2..2^WIDTH-1, odd or even, and produces a one-cycle rising-edge strobe.
- Ratio changes are glitch-free and take effect only at period boundaries. Adds clean start/stop, phase re-alignment of all channels, and per-channel lock indication.
- Sits between the PHY clock source and the PCS/PIPE logic that needs PCLK and word-rate clocks.

---
 rtl/clk_div_multi.sv | 156 +++++++++++++++
 tb/tb_clk_div_multi.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_multi
// Purpose  : Multi-channel integer clock divider. Each of NUM_CH channels
//            divides clk by its own ratio (2..2^WIDTH-1, odd or even) and
//            produces a registered divided clock plus a one-cycle strobe in
//            the cycle that clock rises. Ratio changes only take effect at
//            period boundaries, so no runt pulses are ever produced.
// Ports    : clk        - high-speed source clock, all logic on posedge
//            rst        - asynchronous active-low reset
//            en         - global run enable (level)
//            sync       - one-cycle pulse, restarts every running channel
//            div_ratio  - requested ratios, channel i at [i*WIDTH +: WIDTH]
//            clk_out    - registered divided clocks
//            clk_en     - strobe, high in the cycle clk_out[i] rises
//            locked     - channel has run a full period at the requested ratio
//            ref_clk    - clk passed straight through
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_multi #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sync,
  input  logic [NUM_CH*WIDTH-1:0] div_ratio,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       clk_en,
  output logic [NUM_CH-1:0]       locked,
  output logic                    ref_clk
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  // Raw source clock for consumers that need the undivided rate.
  assign ref_clk = clk;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state, state_nx;
    logic [WIDTH-1:0] count, count_nx;
    logic [WIDTH-1:0] active, active_nx;
    logic             out_q, out_nx;
    logic             strobe_q, strobe_nx;
    logic             lock_q, lock_nx;
    logic [WIDTH-1:0] req_raw;
    logic [WIDTH-1:0] req;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] count_inc;
    logic             wrap;

    // Ratios 0 and 1 cannot be produced; treat them as divide-by-2.
    assign req_raw   = div_ratio[i*WIDTH +: WIDTH];
    assign req       = (req_raw < WIDTH'(2)) ? WIDTH'(2) : req_raw;
    assign half      = active >> 1;
    assign count_inc = count + WIDTH'(1);
    assign wrap      = (count == active - WIDTH'(1));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state    <= ST_IDLE;
        count    <= '0;
        active   <= WIDTH'(2);
        out_q    <= 1'b0;
        strobe_q <= 1'b0;
        lock_q   <= 1'b0;
      end else begin
        state    <= state_nx;
        count    <= count_nx;
        active   <= active_nx;
        out_q    <= out_nx;
        strobe_q <= strobe_nx;
        lock_q   <= lock_nx;
      end
    end

    always_comb begin
      state_nx  = state;
      count_nx  = count;
      active_nx = active;
      out_nx    = out_q;
      strobe_nx = 1'b0;
      lock_nx   = lock_q;

      case (state)
        ST_IDLE: begin
          count_nx = '0;
          out_nx   = 1'b0;
          lock_nx  = 1'b0;
          if (en) begin
            // Start a fresh period: the first rising edge is right now.
            state_nx  = ST_RUN;
            active_nx = req;
            out_nx    = 1'b1;
            strobe_nx = 1'b1;
          end
        end

        ST_RUN, ST_STOP: begin
          if (wrap && !en) begin
            // Period completed with the channel stopping: park low.
            state_nx = ST_IDLE;
            count_nx = '0;
            out_nx   = 1'b0;
            lock_nx  = 1'b0;
          end else begin
            // en low mid-period lets the period run out in STOP; en high
            // again in STOP resumes RUN without touching the period.
            state_nx = en ? ST_RUN : ST_STOP;

            if (wrap || sync) begin
              // Period boundary (natural or forced): only place the ratio
              // may change, so the low phase is never cut short.
              count_nx  = '0;
              active_nx = req;
              out_nx    = 1'b1;
              strobe_nx = 1'b1;
            end else begin
              count_nx = count_inc;
              out_nx   = (count_inc < half);
            end

            // Wrap takes priority over sync so that a coincident sync is
            // indistinguishable from a plain wrap.
            if (!en) begin
              lock_nx = 1'b0;
            end else if (wrap) begin
              lock_nx = (active == req);
            end else if (sync || (active != req)) begin
              lock_nx = 1'b0;
            end
          end
        end

        default: begin
          state_nx  = ST_IDLE;
          count_nx  = '0;
          active_nx = WIDTH'(2);
          out_nx    = 1'b0;
          lock_nx   = 1'b0;
        end
      endcase
    end

    assign clk_out[i] = out_q;
    assign clk_en[i]  = strobe_q;
    assign locked[i]  = lock_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_multi
// Purpose  : Self-checking bench for clk_div_multi. A period-position model
//            predicts clk_out/clk_en/locked every cycle; directed sections
//            pin the model with hand-derived waveforms, then a long random
//            section exercises ratio changes, en, sync and resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_multi;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 2;

  logic                    clk;
  logic                    rst;
  logic                    en;
  logic                    sync;
  logic [NUM_CH*WIDTH-1:0] div_ratio;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       clk_en;
  logic [NUM_CH-1:0]       locked;
  logic                    ref_clk;

  clk_div_multi #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sync      (sync),
    .div_ratio (div_ratio),
    .clk_out   (clk_out),
    .clk_en    (clk_en),
    .locked    (locked),
    .ref_clk   (ref_clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  bit chk_on;

  // Model: each channel is idle (0), running (1) or stopping (2); when not
  // idle it sits at position pos within a period of length len.
  int m_mode [NUM_CH];
  int m_pos  [NUM_CH];
  int m_len  [NUM_CH];
  int m_lk   [NUM_CH];
  logic [NUM_CH-1:0] e_out;
  logic [NUM_CH-1:0] e_en;
  logic [NUM_CH-1:0] e_lk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_mode[c] = 0;
      m_pos[c]  = 0;
      m_len[c]  = 2;
      m_lk[c]   = 0;
    end
    e_out = '0;
    e_en  = '0;
    e_lk  = '0;
  endtask

  task automatic model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      int req;
      bit last;
      req = int'(div_ratio[c*WIDTH +: WIDTH]);
      if (req < 2) req = 2;
      e_en[c] = 1'b0;
      if (m_mode[c] == 0) begin
        m_pos[c] = 0;
        m_lk[c]  = 0;
        if (en) begin
          m_mode[c] = 1;
          m_len[c]  = req;
          e_en[c]   = 1'b1;
        end
      end else begin
        last = (m_pos[c] == m_len[c] - 1);
        if (last && !en) begin
          m_mode[c] = 0;
          m_pos[c]  = 0;
          m_lk[c]   = 0;
        end else begin
          if (!en)                         m_lk[c] = 0;
          else if (last)                   m_lk[c] = (m_len[c] == req) ? 1 : 0;
          else if (sync || m_len[c] != req) m_lk[c] = 0;
          if (last || sync) begin
            m_pos[c] = 0;
            m_len[c] = req;
            e_en[c]  = 1'b1;
          end else begin
            m_pos[c] = m_pos[c] + 1;
          end
          m_mode[c] = en ? 1 : 2;
        end
      end
      e_out[c] = (m_mode[c] != 0) && (m_pos[c] < m_len[c] / 2);
      e_lk[c]  = (m_lk[c] != 0);
    end
  endtask

  always @(negedge rst) model_reset();

  // Compare process: model advances on every edge, DUT checked 1 time unit later.
  always @(posedge clk) begin
    if (!rst) model_reset();
    else      model_step();
    #1;
    if (chk_on) begin
      chk("model_clk_out", 32'(clk_out), 32'(e_out));
      chk("model_clk_en",  32'(clk_en),  32'(e_en));
      chk("model_locked",  32'(locked),  32'(e_lk));
    end
  end

  // Advance one edge; returns with outputs settled, inputs may be changed.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    en   = 1'b0;
    sync = 1'b0;
    rst  = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic async_reset_check(input string tag);
    rst = 1'b0;
    #1;
    chk({tag, "_out"},    32'(clk_out), 32'd0);
    chk({tag, "_en"},     32'(clk_en),  32'd0);
    chk({tag, "_lk"},     32'(locked),  32'd0);
    chk({tag, "_ref_hi"}, 32'(ref_clk), 32'd1);
    @(negedge clk);
    #1;
    chk({tag, "_ref_lo"}, 32'(ref_clk), 32'd0);
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    chk_on      = 1'b0;
    en          = 1'b0;
    sync        = 1'b0;
    div_ratio   = '0;
    rst         = 1'b1;
    #1 rst      = 1'b0;
    cyc();
    cyc();
    rst    = 1'b1;
    chk_on = 1'b1;
    cyc();
    chk("reset_out", 32'(clk_out), 32'd0);
    chk("reset_en",  32'(clk_en),  32'd0);
    chk("reset_lk",  32'(locked),  32'd0);

    // Ratios {4,10}: 2/2 and 5/5 waveforms, lock after the first period.
    do_reset();
    div_ratio = {8'd10, 8'd4};
    en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cyc();
      chk("r4_out0", 32'(clk_out[0]), 32'((i % 4) < 2));
      chk("r10_out1", 32'(clk_out[1]), 32'((i % 10) < 5));
      chk("r4_en0",  32'(clk_en[0]),  32'((i % 4) == 0));
      chk("r10_en1", 32'(clk_en[1]),  32'((i % 10) == 0));
      chk("r4_lk0",  32'(locked[0]),  32'(i >= 4));
      chk("r10_lk1", 32'(locked[1]),  32'(i >= 10));
    end

    // Odd ratio 5 (2 high / 3 low); ratio 1 then 0 both act as 2.
    do_reset();
    div_ratio = {8'd1, 8'd5};
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("r5_out0", 32'(clk_out[0]), 32'((i % 5) < 2));
      chk("r5_lk0",  32'(locked[0]),  32'(i >= 5));
      chk("r1_out1", 32'(clk_out[1]), 32'((i % 2) == 0));
      chk("r1_en1",  32'(clk_en[1]),  32'((i % 2) == 0));
      chk("r1_lk1",  32'(locked[1]),  32'(i >= 2));
      if (i == 9) div_ratio[15:8] = 8'd0;
    end

    // Ratio change 4 -> 6 at count 1: period finishes at 4, then 6.
    do_reset();
    div_ratio = {8'd4, 8'd4};
    en = 1'b1;
    for (int i = 0; i < 26; i++) begin
      cyc();
      chk("chg_out0", 32'(clk_out[0]),
          32'((i < 12) ? ((i % 4) < 2) : (((i - 12) % 6) < 3)));
      chk("chg_en0", 32'(clk_en[0]),
          32'((i < 12) ? ((i % 4) == 0) : (((i - 12) % 6) == 0)));
      chk("chg_lk0", 32'(locked[0]),
          32'((i >= 4 && i <= 9) || i >= 18));
      if (i == 9) div_ratio[7:0] = 8'd6;
    end

    // en dropped at count 1 of a ratio-8 period, re-raised later.
    do_reset();
    div_ratio = {8'd3, 8'd8};
    en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      cyc();
      chk("stop_out0", 32'(clk_out[0]), 32'(i < 4 || i == 12));
      chk("stop_en0",  32'(clk_en[0]),  32'(i == 0 || i == 12));
      chk("stop_out1", 32'(clk_out[1]), 32'(i == 0 || i == 12));
      if (i == 1)  en = 1'b0;
      if (i == 11) en = 1'b1;
    end

    // Ratios {3,7} with a mid-period sync.
    do_reset();
    div_ratio = {8'd7, 8'd3};
    en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cyc();
      sync = 1'b0;
      if (i == 20) begin
        chk("sync_out", 32'(clk_out), 32'd3);
        chk("sync_en",  32'(clk_en),  32'd3);
      end
      chk("sync_lk0", 32'(locked[0]), 32'((i >= 3 && i < 20) || i >= 23));
      chk("sync_lk1", 32'(locked[1]), 32'((i >= 7 && i < 20) || i >= 27));
      if (i == 19) sync = 1'b1;
    end

    // Asynchronous reset in the middle of a period.
    do_reset();
    div_ratio = {8'd6, 8'd4};
    en = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    async_reset_check("areset");

    // Randomised section.
    en = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      sync = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 39) == 0) en = ~en;
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 24) == 0) begin
          if ($urandom_range(0, 9) == 0)
            div_ratio[c*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
          else
            div_ratio[c*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 12));
        end
      end
      cyc();
      if ($urandom_range(0, 799) == 0) async_reset_check("rnd_areset");
    end
    sync = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
